// File: rtl/int_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | int_divider: radix-2 restoring divider, RISC-V DIV/DIVU/REM/REMU results.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module int_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             dz_o,
  output logic             ov_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz_flag;
  logic             ov_flag;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             is_dz;
  logic             is_ov;
  logic [WIDTH:0]   shifted;
  logic             fits;

  assign a_neg = signed_i & dividend_i[WIDTH-1];
  assign b_neg = signed_i & divisor_i[WIDTH-1];
  // Negating MIN yields 2^(W-1), which is exact when read as unsigned.
  assign a_mag = a_neg ? -dividend_i : dividend_i;
  assign b_mag = b_neg ? -divisor_i  : divisor_i;
  assign is_dz = (divisor_i == '0);
  assign is_ov = signed_i && (dividend_i == MIN_VAL) && (divisor_i == '1);

  // Partial remainder keeps its top bit: with a large unsigned divisor it can exceed 2^(W-1).
  assign shifted = {prem, dvd[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvs});

  assign busy_o = (state == S_CALC) || (state == S_FIX);
  assign done_o = (state == S_DONE);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state   <= S_IDLE;
      dvd     <= '0;
      dvs     <= '0;
      prem    <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_flag <= 1'b0;
      ov_flag <= 1'b0;
      quot_o  <= '0;
      rem_o   <= '0;
      dz_o    <= 1'b0;
      ov_o    <= 1'b0;
    end else if (abort_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            cnt <= CNT_INIT;
            dvs <= b_mag;
            // Special cases preload the quotient/remainder registers so FIX stays uniform.
            if (is_dz) begin
              dvd     <= '1;
              prem    <= dividend_i;
              neg_q   <= 1'b0;
              neg_r   <= 1'b0;
              dz_flag <= 1'b1;
              ov_flag <= 1'b0;
              state   <= S_FIX;
            end else if (is_ov) begin
              dvd     <= MIN_VAL;
              prem    <= '0;
              neg_q   <= 1'b0;
              neg_r   <= 1'b0;
              dz_flag <= 1'b0;
              ov_flag <= 1'b1;
              state   <= S_FIX;
            end else begin
              dvd     <= a_mag;
              prem    <= '0;
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              dz_flag <= 1'b0;
              ov_flag <= 1'b0;
              state   <= S_CALC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          dvd  <= {dvd[WIDTH-2:0], fits};
          prem <= fits ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
          cnt  <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          quot_o <= neg_q ? -dvd  : dvd;
          rem_o  <= neg_r ? -prem : prem;
          dz_o   <= dz_flag;
          ov_o   <= ov_flag;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_divider.sv
`default_nettype none
// Scoreboard bench for int_divider: randomized operands against an arithmetic reference model.
module tb_int_divider;

  localparam int W = 64;
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sgn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         abort;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         dz;
  logic         ov;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last_exp = '{q: '0, r: '0, dz: 1'b0, ov: 1'b0};

  int_divider #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .signed_i(sgn),
    .dividend_i(dividend), .divisor_i(divisor), .abort_i(abort),
    .busy_o(busy), .done_o(done), .quot_o(quot), .rem_o(rem),
    .dz_o(dz), .ov_o(ov)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // RISC-V division semantics using the simulator's own arithmetic.
  function automatic exp_t model(bit s, logic [W-1:0] a, logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_;
    e = '{q: '0, r: '0, dz: 1'b0, ov: 1'b0};
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (s && a == MIN_V && b == '1) begin
      e.q = MIN_V; e.r = '0; e.ov = 1'b1;
    end else if (s) begin
      sa = a; sb_ = b;
      e.q = sa / sb_; e.r = sa % sb_;
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  function automatic int exp_lat(bit s, logic [W-1:0] a, logic [W-1:0] b);
    return (b == '0 || (s && a == MIN_V && b == '1)) ? 2 : W + 2;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 64'd1;
      2: v = '1;
      3: v = MIN_V;
      4: v = 64'($urandom_range(0, 1000));
      5: v = -64'($urandom_range(1, 1000));
      6: v = {$urandom, $urandom} >> $urandom_range(0, 63);
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got quot=%h rem=%h, no op outstanding", quot, rem);
      end else begin
        e = sb.pop_front();
        chk("quot", quot, e.q);
        chk("rem",  rem,  e.r);
        chk("dz",   W'(dz), W'(e.dz));
        chk("ov",   W'(ov), W'(e.ov));
      end
    end
  end

  task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(negedge clk);
    sgn = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    if (push) begin
      last_exp = model(s, a, b);
      sb.push_back(last_exp);
    end
    #1;
    start    = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    sgn      = 1'($urandom);
  endtask

  // Returns the edge number (accept edge = 1) after which done was seen, and busy cycle count.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 1;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d edges, required done", lat);
    end
  endtask

  task automatic run(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, bn;
    issue(s, a, b, 1'b1);
    wait_done(lat, bn);
    chk("latency", W'(lat), W'(exp_lat(s, a, b)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bn, seen;
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; abort = 1'b0;
    dividend = '0; divisor = '0;
    #3;
    chk("rst_quot", quot, '0);
    chk("rst_rem",  rem,  '0);
    chk("rst_flags", W'({dz, ov, busy, done}), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unsigned 100/7: full-length latency and busy duration.
    issue(1'b0, 64'd100, 64'd7, 1'b1);
    chk("busy_after_accept", W'(busy), W'(1));
    wait_done(lat, bn);
    chk("t1_latency", W'(lat), W'(W + 2));
    chk("t1_busy_cycles", W'(bn), W'(W + 1));
    chk("t1_quot_const", quot, 64'd14);
    chk("t1_rem_const",  rem,  64'd2);

    run(1'b1, -64'sd7, 64'd2);
    chk("t2_quot_const", quot, 64'hFFFF_FFFF_FFFF_FFFD);
    run(1'b1, 64'd7, -64'sd2);
    run(1'b0, 64'h1234, 64'd0);
    run(1'b1, 64'h1234, 64'd0);
    run(1'b1, MIN_V, '1);
    run(1'b0, MIN_V, '1);
    run(1'b0, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    run(1'b1, MIN_V, 64'd1);

    // Abort during CALC: no done, previous results hold.
    issue(1'b0, 64'd1000, 64'd3, 1'b0);
    repeat (29) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", W'({busy, done}), '0);
    chk("abort_hold_quot", quot, last_exp.q);
    chk("abort_hold_rem",  rem,  last_exp.r);
    chk("abort_hold_flags", W'({dz, ov}), W'({last_exp.dz, last_exp.ov}));
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("abort_no_done", W'(seen), '0);
    // Abort wins over a simultaneous start.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; divisor = 64'd5;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_over_start", W'(busy), '0);
    run(1'b1, -64'sd100, 64'd9);

    // Back-to-back: start asserted while in DONE is accepted on that edge.
    issue(1'b0, 64'd5000, 64'd13, 1'b1);
    wait_done(lat, bn);
    issue(1'b1, -64'sd5000, 64'd13, 1'b1);
    chk("b2b_accept_busy", W'(busy), W'(1));
    wait_done(lat, bn);
    chk("b2b_latency", W'(lat), W'(W + 2));

    // Async reset mid-CALC clears outputs without waiting for a clock edge.
    issue(1'b1, 64'd77777, 64'd3, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_quot", quot, '0);
    chk("arst_rem",  rem,  '0);
    chk("arst_flags", W'({dz, ov, busy, done}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = '{q: '0, r: '0, dz: 1'b0, ov: 1'b0};

    for (int i = 0; i < 50; i++) begin
      logic [W-1:0] a, b;
      a = pick();
      b = pick();
      run(1'($urandom), a, b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", W'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
